// File: rtl/display_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner_pkg
// Description : Shared symbol codes, digit count and position encoding for
//               the 4-digit scrolling step display.
// Revision    : 1.0 - initial release
// ============================================================================
package display_scanner_pkg;

    // Step symbols as understood by the segment pattern selector
    typedef enum logic [2:0] {
        SYM_UP      = 3'd0,
        SYM_DOWN    = 3'd1,
        SYM_LEFT    = 3'd2,
        SYM_RIGHT   = 3'd3,
        SYM_BLANK   = 3'd4,
        SYM_BAR_LOW = 3'd5,
        SYM_BAR_MID = 3'd6
    } sym_e;

    // Raw symbol storage; any 3-bit code may be pushed, not only named ones
    typedef logic [2:0] sym_t;

    // Digit position: 0 is the rightmost digit, 3 the leftmost
    typedef logic [1:0] pos_t;

    localparam int   c_NUM_DIGITS  = 4;
    localparam pos_t c_POS_RIGHT   = 2'd0;
    localparam pos_t c_POS_LEFT    = 2'd3;

endpackage : display_scanner_pkg
`default_nettype wire

// File: rtl/display_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner_if
// Description : Symbol-push side and display/exit side of the scanner.
//               slave = scanner, master = the logic that drives and observes it.
// Revision    : 1.0 - initial release
// ============================================================================
interface display_scanner_if;
    import display_scanner_pkg::*;

    logic       push;
    sym_t       push_num;
    logic       clear;
    pos_t       pos;
    sym_t       num;
    logic [3:0] an;
    logic       exit_valid;
    sym_t       exit_num;

    modport master (
        output push, push_num, clear,
        input  pos, num, an, exit_valid, exit_num
    );

    modport slave (
        input  push, push_num, clear,
        output pos, num, an, exit_valid, exit_num
    );
endinterface : display_scanner_if
`default_nettype wire

// File: rtl/display_scanner_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_timer
// Description : Refresh counter and scanned digit position. Emits the wrap
//               strobe of the current cycle and the blank flag that the
//               counter will carry after the next edge, so the caller can
//               register anodes in step with the counter.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_timer
    import display_scanner_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  wire logic clk,
    input  wire logic rst_n,
    output pos_t      o_pos,
    output logic      o_blank_next,
    output logic      o_wrap
);

    localparam int               CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] c_BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    pos_t             r_pos;
    pos_t             w_pos_next;
    logic             w_wrap;

    // Next counter / position: wrap the counter and step the digit together
    always_comb begin
        w_wrap     = (r_cnt == c_CNT_LAST);
        w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
        w_pos_next = w_wrap ? r_pos + 2'd1 : r_pos;
    end

    // Counter and position registers; reset restarts scanning at digit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_pos <= c_POS_RIGHT;
        end else begin
            r_cnt <= w_cnt_next;
            r_pos <= w_pos_next;
        end
    end

    assign o_pos        = r_pos;
    assign o_wrap       = w_wrap;
    assign o_blank_next = (w_cnt_next < c_BLANK_END);

endmodule : scan_timer
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner
// Description : 4-slot scrolling symbol lane multiplexed onto a 4-digit
//               7-segment display. Symbols enter at the leftmost slot and
//               the one shifted out of slot 0 is reported for scoring.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int   REFRESH_DIV  = 50000,
    parameter int   BLANK_CYCLES = 500,
    parameter sym_t BLANK_SYM    = sym_t'(SYM_BLANK)
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    display_scanner_if.slave  bus
);

    sym_t       r_slots [c_NUM_DIGITS];
    sym_t       r_num;
    logic [3:0] r_an;
    logic       r_exit_valid;
    sym_t       r_exit_num;

    pos_t       w_pos;
    pos_t       w_pos_next;
    logic       w_blank_next;
    logic       w_wrap;

    scan_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_pos        (w_pos),
        .o_blank_next (w_blank_next),
        .o_wrap       (w_wrap)
    );

    // Position the timer will hold after this edge; num/an are aligned to it
    assign w_pos_next = w_wrap ? w_pos + 2'd1 : w_pos;

    // Lane shift register with exit report; clear wins over push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM_DIGITS; i++) begin
                r_slots[i] <= BLANK_SYM;
            end
            r_exit_valid <= 1'b0;
            r_exit_num   <= BLANK_SYM;
        end else if (bus.clear) begin
            for (int i = 0; i < c_NUM_DIGITS; i++) begin
                r_slots[i] <= BLANK_SYM;
            end
            r_exit_valid <= 1'b0;
        end else if (bus.push) begin
            for (int i = 0; i < c_NUM_DIGITS - 1; i++) begin
                r_slots[i] <= r_slots[i+1];
            end
            r_slots[c_NUM_DIGITS-1] <= bus.push_num;
            r_exit_valid            <= 1'b1;
            r_exit_num              <= r_slots[0];
        end else begin
            r_exit_valid <= 1'b0;
        end
    end

    // Displayed symbol and anodes, registered so they change with pos
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num <= BLANK_SYM;
            r_an  <= 4'b1111;
        end else begin
            r_num <= r_slots[w_pos_next];
            r_an  <= w_blank_next ? 4'b1111 : ~(4'b0001 << w_pos_next);
        end
    end

    assign bus.pos        = w_pos;
    assign bus.num        = r_num;
    assign bus.an         = r_an;
    assign bus.exit_valid = r_exit_valid;
    assign bus.exit_num   = r_exit_num;

endmodule : display_scanner
`default_nettype wire
